nibble_packer: RTL and testbench
================================

# nibble_packer

Collects a stream of 4-bit nibbles into 32-bit words and delivers each finished word to one of two destination ports, A or B, each with a valid/ready handshake. It performs the inverse of the nibble-selection path: it rebuilds the `dataA`/`dataB` words that the selector later slices. Nibble position 0 occupies the least significant bits. Each word's destination uses the same `sel` convention as the selector: 0 selects A, 1 selects B.

## Interface
- `WORD_NIBBLES`, default 8: nibbles per word. Word width is 4*`WORD_NIBBLES`. The count width is clog2(`WORD_NIBBLES`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `nibbleIn`  in  4  input nibble.
- `nibbleValid`  in  1  `nibbleIn` is valid this cycle.
- `nibbleReady`  out  1  registered; the block accepts a nibble this cycle.
- `sel`  in  1  destination (0 = A, 1 = B); sampled only with the first nibble of a word.
- `dataA`  out  32  assembled word for port A.
- `dataAValid`  out  1  `dataA` holds an undelivered word.
- `dataAReady`  in  1  port A consumer accepts the word.
- `dataB`  out  32  assembled word for port B.
- `dataBValid`  out  1  `dataB` holds an undelivered word.
- `dataBReady`  in  1  port B consumer accepts the word.
- `count`  out  3  nibbles accumulated in the current word (0..7).

## Operation
- Handshakes:
  - A nibble is accepted when `nibbleValid` & `nibbleReady` at an edge.
  - A word is delivered on port X when `dataXValid` & `dataXReady` at an edge.
- Nibble k of a word (k = 0..7) goes to bits [4k+3:4k].
- State machine:
  - **IDLE** (count = 0): on accept, store nibble 0, latch `sel` into an internal destination bit, set count = 1, go to FILL.
  - **FILL**:
    - On an accept with count < 7: store the nibble and increment count.
    - On the accept with count = 7, the word is {`nibbleIn`, acc[27:0]}:
      - If the destination register is free, load it, set its valid to 1, set count = 0, go to IDLE.
      - Otherwise hold the word internally, set count = 0, go to FULL.
  - **FULL**: `nibbleReady` = 0. At the first edge where the destination register is free, load it, set valid to 1, go to IDLE.
- "Destination register free" means `dataXValid` = 0, or `dataXReady` = 1 at that same edge (drain and refill in one edge; valid stays 1).
- Output data and valid:
  - `dataX` is stable while `dataXValid` = 1.
  - `dataXValid` clears on delivery unless the register is refilled at the same edge.
- Ports A and B drain independently. A stalled port never blocks a word bound for the other port until that word completes.
- `sel` changes after nibble 0 are ignored for the current word.
- `nibbleReady` is registered: it is 1 in IDLE and FILL, and 0 in FULL.

## Timing
- Reset values: `dataA` = `dataB` = 0, `dataAValid` = `dataBValid` = 0, `count` = 0, `nibbleReady` = 0, state IDLE, accumulator cleared.
- `nibbleReady` rises at the first edge after `reset_L` deasserts.
- Asserting `reset_L` mid-word discards the partial word and any FULL-held word immediately, without waiting for a clock edge.
- Latency: if the 8th nibble is accepted at edge N and the destination is free, `dataXValid` = 1 after edge N.
- Throughput: one nibble per cycle; one word every 8 cycles with no bubbles while the consumer keeps its ready high.
- Entering FULL at edge N makes `nibbleReady` = 0 after edge N.
- Leaving FULL at edge M makes `nibbleReady` = 1 after edge M; the next nibble can be accepted at edge M+1.
- Cycles with `nibbleValid` = 0 leave `count`, the accumulator and the destination bit unchanged.

## Test plan
- **Reset**: hold `reset_L` = 0 for 3 cycles, then release -> all outputs 0 during reset; `nibbleReady` = 1 one edge after release; `count` = 0.
- **Word to A**: `sel` = 0, nibbles 1,2,...,8 on consecutive cycles, `dataAReady` = 1 -> `dataA` = 0x87654321; `dataAValid` high for exactly 1 cycle, starting after the 8th accept; `dataBValid` stays 0.
- **Word to B, sel ignored after nibble 0**: `sel` = 1 on nibble 0, then toggled every cycle; nibbles F,E,E,B,D,A,E,D -> `dataB` = 0xDEADBEEF with `dataBValid` = 1; `dataA` is unchanged.
- **Backpressure**: `dataAReady` = 0; send two words to A (0x11111111, then 0x22222222) -> the first is held on `dataA`; after the second's 8th accept, `nibbleReady` = 0 and `count` = 0. Raise `dataAReady` for 1 cycle -> `dataA` becomes 0x22222222 with `dataAValid` still 1; `nibbleReady` = 1 on the next cycle.
- **Gaps and independence**: insert `nibbleValid` = 0 bubbles at count = 3 -> `count` holds 3 and the final word is correct. With `dataAValid` stuck (ready = 0), a word to B still completes and is delivered.
- **Reset mid-word**: assert `reset_L` = 0 asynchronously at count = 5 -> `count` = 0 immediately and valids = 0. After release, the next 8 nibbles form a clean word with no leftover bits.

Source files
------------

// File: rtl/nibble_packer.sv
// nibble_packer
//   Collects a stream of 4-bit nibbles into words of WORD_NIBBLES nibbles
//   (nibble 0 in the least significant bits) and hands each finished word to
//   port A or port B, chosen by `sel` sampled with nibble 0 of the word.
//
// Ports
//   clk          single clock, rising edge
//   reset_L      asynchronous active-low reset
//   nibbleIn     input nibble
//   nibbleValid  nibbleIn is valid this cycle
//   nibbleReady  registered; packer accepts a nibble this cycle
//   sel          destination of the word (0 = A, 1 = B), used with nibble 0 only
//   dataA/B      assembled word for port A / B
//   dataAValid/B dataA/B holds an undelivered word
//   dataAReady/B consumer of port A / B takes the word
//   count        nibbles accumulated in the current word
//   state_dbg    current FSM state (0 = IDLE, 1 = FILL, 2 = FULL)
//
// Handshake: a transfer happens at a rising edge where valid and ready are
// both 1. Valid never depends combinationally on ready, and data is held
// stable while valid is 1 and the transfer has not yet happened.

module nibble_packer #(
   parameter int WORD_NIBBLES = 8,
   localparam int WORD_W = 4 * WORD_NIBBLES,
   localparam int CNT_W = $clog2(WORD_NIBBLES)
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [3:0]        nibbleIn,
   input  logic              nibbleValid,
   output logic              nibbleReady,
   input  logic              sel,
   output logic [WORD_W-1:0] dataA,
   output logic              dataAValid,
   input  logic              dataAReady,
   output logic [WORD_W-1:0] dataB,
   output logic              dataBValid,
   input  logic              dataBReady,
   output logic [CNT_W-1:0]  count,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_FULL = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_NIBBLES - 1);

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   acc_q, acc_d;
   logic [WORD_W-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                dest_q, dest_d;
   logic                ready_q, ready_d;
   logic [WORD_W-1:0]   data_a_q, data_a_d;
   logic [WORD_W-1:0]   data_b_q, data_b_d;
   logic                a_valid_q, a_valid_d;
   logic                b_valid_q, b_valid_d;

   logic                accept;
   logic                a_free;
   logic                b_free;
   logic                dest_free;
   logic [WORD_W-1:0]   word_full;
   logic [WORD_W-1:0]   load_word;
   logic                load_a;
   logic                load_b;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      hold_d    = hold_q;
      count_d   = count_q;
      dest_d    = dest_q;
      data_a_d  = data_a_q;
      data_b_d  = data_b_q;
      // A delivery at this edge empties the register unless it is refilled below.
      a_valid_d = a_valid_q & ~dataAReady;
      b_valid_d = b_valid_q & ~dataBReady;
      load_word = '0;
      load_a    = 1'b0;
      load_b    = 1'b0;

      accept    = nibbleValid & ready_q;
      // A register is free if empty or being drained at this same edge.
      a_free    = ~a_valid_q | dataAReady;
      b_free    = ~b_valid_q | dataBReady;
      dest_free = dest_q ? b_free : a_free;

      // Completed word: accumulated nibbles with the incoming one on top.
      word_full                   = acc_q;
      word_full[WORD_W-1 -: 4]    = nibbleIn;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               acc_d          = '0;
               acc_d[3:0]     = nibbleIn;
               dest_d         = sel;
               count_d        = CNT_W'(1);
               state_d        = ST_FILL;
            end
         end
         ST_FILL: begin
            if (accept) begin
               if (count_q == LAST) begin
                  count_d = '0;
                  acc_d   = '0;
                  if (dest_free) begin
                     load_word = word_full;
                     load_a    = ~dest_q;
                     load_b    = dest_q;
                     state_d   = ST_IDLE;
                  end else begin
                     hold_d  = word_full;
                     state_d = ST_FULL;
                  end
               end else begin
                  acc_d[{count_q, 2'b00} +: 4] = nibbleIn;
                  count_d                      = count_q + CNT_W'(1);
               end
            end
         end
         ST_FULL: begin
            if (dest_free) begin
               load_word = hold_q;
               load_a    = ~dest_q;
               load_b    = dest_q;
               hold_d    = '0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load_a) begin
         data_a_d  = load_word;
         a_valid_d = 1'b1;
      end
      if (load_b) begin
         data_b_d  = load_word;
         b_valid_d = 1'b1;
      end

      // Registered ready: low exactly while a finished word waits in FULL.
      ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         hold_q    <= '0;
         count_q   <= '0;
         dest_q    <= 1'b0;
         ready_q   <= 1'b0;
         data_a_q  <= '0;
         data_b_q  <= '0;
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         hold_q    <= hold_d;
         count_q   <= count_d;
         dest_q    <= dest_d;
         ready_q   <= ready_d;
         data_a_q  <= data_a_d;
         data_b_q  <= data_b_d;
         a_valid_q <= a_valid_d;
         b_valid_q <= b_valid_d;
      end
   end

   assign nibbleReady = ready_q;
   assign dataA       = data_a_q;
   assign dataAValid  = a_valid_q;
   assign dataB       = data_b_q;
   assign dataBValid  = b_valid_q;
   assign count       = count_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer
//   Directed scenarios for reset, routing, backpressure, bubbles and
//   asynchronous reset, followed by a randomized run scored against
//   per-port queues of expected words built from the nibble stream.

module tb_nibble_packer;

   localparam int NW = 30;

   logic        clk = 1'b0;
   logic        reset_L;
   logic [3:0]  nibbleIn;
   logic        nibbleValid;
   logic        nibbleReady;
   logic        sel;
   logic [31:0] dataA;
   logic        dataAValid;
   logic        dataAReady;
   logic [31:0] dataB;
   logic        dataBValid;
   logic        dataBReady;
   logic [2:0]  count;
   logic [1:0]  state_dbg;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_a_q[$];
   logic [31:0] exp_b_q[$];
   logic [3:0]  nibs[NW][8];
   logic        sels[NW];
   int          wi;
   int          ni;
   int          cyc;

   always #5 clk = ~clk;

   nibble_packer #(.WORD_NIBBLES(8)) dut (
      .clk         (clk),
      .reset_L     (reset_L),
      .nibbleIn    (nibbleIn),
      .nibbleValid (nibbleValid),
      .nibbleReady (nibbleReady),
      .sel         (sel),
      .dataA       (dataA),
      .dataAValid  (dataAValid),
      .dataAReady  (dataAReady),
      .dataB       (dataB),
      .dataBValid  (dataBValid),
      .dataBReady  (dataBReady),
      .count       (count),
      .state_dbg   (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one nibble and wait (bounded) until it is taken at an edge.
   task automatic push(input logic [3:0] n, input logic s);
      int budget;
      budget      = 0;
      nibbleValid = 1'b1;
      nibbleIn    = n;
      sel         = s;
      while (!nibbleReady && budget < 20) begin
         tick();
         budget++;
      end
      if (!nibbleReady) check("push_ready_timeout", {31'd0, nibbleReady}, 32'd1);
      tick();
   endtask

   // Send a whole word; sel toggles after nibble 0 and must be ignored.
   task automatic send_word(input logic [31:0] w, input logic s);
      logic [31:0] tmp;
      tmp = w;
      for (int k = 0; k < 8; k++) begin
         push(tmp[4*k +: 4], (k == 0) ? s : (s ^ k[0]));
      end
      nibbleValid = 1'b0;
   endtask

   // Score deliveries happening at the coming edge.
   task automatic score_edge();
      if (dataAValid && dataAReady) begin
         if (exp_a_q.size() == 0) check("rand_a_unexpected", 32'd1, 32'd0);
         else check("rand_dataA", dataA, exp_a_q.pop_front());
      end
      if (dataBValid && dataBReady) begin
         if (exp_b_q.size() == 0) check("rand_b_unexpected", 32'd1, 32'd0);
         else check("rand_dataB", dataB, exp_b_q.pop_front());
      end
   endtask

   function automatic logic [31:0] model_word(input int w);
      logic [31:0] r;
      r = 32'd0;
      for (int k = 0; k < 8; k++) r = r + (32'(nibs[w][k]) << (4 * k));
      return r;
   endfunction

   initial begin
      reset_L     = 1'b1;
      nibbleIn    = 4'd0;
      nibbleValid = 1'b0;
      sel         = 1'b0;
      dataAReady  = 1'b0;
      dataBReady  = 1'b0;

      // ---------------- Reset ----------------
      #2 reset_L = 1'b0;
      tick();
      tick();
      tick();
      check("rst_nibbleReady", {31'd0, nibbleReady}, 32'd0);
      check("rst_dataAValid",  {31'd0, dataAValid},  32'd0);
      check("rst_dataBValid",  {31'd0, dataBValid},  32'd0);
      check("rst_dataA",       dataA,                32'd0);
      check("rst_dataB",       dataB,                32'd0);
      check("rst_count",       {29'd0, count},       32'd0);
      check("rst_state",       {30'd0, state_dbg},   32'd0);
      reset_L = 1'b1;
      tick();
      check("rel_nibbleReady", {31'd0, nibbleReady}, 32'd1);
      check("rel_count",       {29'd0, count},       32'd0);

      // ---------------- Word to A ----------------
      dataAReady = 1'b1;
      dataBReady = 1'b1;
      for (int k = 0; k < 8; k++) begin
         push(4'(k + 1), 1'b0);
         if (k == 6) begin
            check("a_count7",     {29'd0, count},      32'd7);
            check("a_early_valid", {31'd0, dataAValid}, 32'd0);
         end
      end
      nibbleValid = 1'b0;
      check("a_valid",      {31'd0, dataAValid}, 32'd1);
      check("a_data",       dataA,               32'h87654321);
      check("a_bvalid",     {31'd0, dataBValid}, 32'd0);
      check("a_count0",     {29'd0, count},      32'd0);
      tick();
      check("a_valid_1cyc", {31'd0, dataAValid}, 32'd0);

      // ---------------- Word to B, sel ignored after nibble 0 ----------------
      dataBReady = 1'b0;
      send_word(32'hDEADBEEF, 1'b1);
      check("b_valid",     {31'd0, dataBValid}, 32'd1);
      check("b_data",      dataB,               32'hDEADBEEF);
      check("b_a_same",    dataA,               32'h87654321);
      check("b_a_valid",   {31'd0, dataAValid}, 32'd0);
      dataBReady = 1'b1;
      tick();
      check("b_drained",   {31'd0, dataBValid}, 32'd0);

      // ---------------- Backpressure ----------------
      dataAReady = 1'b0;
      send_word(32'h11111111, 1'b0);
      check("bp_first_valid", {31'd0, dataAValid}, 32'd1);
      check("bp_first_data",  dataA,               32'h11111111);
      send_word(32'h22222222, 1'b0);
      check("bp_full_ready",  {31'd0, nibbleReady}, 32'd0);
      check("bp_full_count",  {29'd0, count},       32'd0);
      check("bp_full_held",   dataA,                32'h11111111);
      tick();
      check("bp_still_full",  {31'd0, nibbleReady}, 32'd0);
      dataAReady = 1'b1;
      tick();
      dataAReady = 1'b0;
      check("bp_refill_data",  dataA,               32'h22222222);
      check("bp_refill_valid", {31'd0, dataAValid}, 32'd1);
      check("bp_ready_back",   {31'd0, nibbleReady}, 32'd1);
      dataAReady = 1'b1;
      tick();
      check("bp_drained",      {31'd0, dataAValid}, 32'd0);

      // ---------------- Gaps ----------------
      push(4'h5, 1'b0);
      push(4'h6, 1'b0);
      push(4'h7, 1'b0);
      nibbleValid = 1'b0;
      for (int g = 0; g < 3; g++) begin
         tick();
         check("gap_count_hold", {29'd0, count}, 32'd3);
      end
      push(4'h8, 1'b1);
      push(4'h9, 1'b1);
      push(4'hA, 1'b1);
      push(4'hB, 1'b1);
      push(4'hC, 1'b1);
      nibbleValid = 1'b0;
      check("gap_word",  dataA,               32'hCBA98765);
      check("gap_valid", {31'd0, dataAValid}, 32'd1);
      tick();

      // ---------------- Independence ----------------
      dataAReady = 1'b0;
      send_word(32'hA5A5A5A5, 1'b0);
      check("ind_a_valid", {31'd0, dataAValid}, 32'd1);
      dataBReady = 1'b1;
      send_word(32'h3C69F00D, 1'b1);
      check("ind_b_valid", {31'd0, dataBValid}, 32'd1);
      check("ind_b_data",  dataB,               32'h3C69F00D);
      check("ind_a_stuck", {31'd0, dataAValid}, 32'd1);
      check("ind_a_data",  dataA,               32'hA5A5A5A5);
      tick();
      check("ind_b_drained", {31'd0, dataBValid}, 32'd0);
      dataAReady = 1'b1;
      tick();
      check("ind_a_drained", {31'd0, dataAValid}, 32'd0);

      // ---------------- Reset mid-word ----------------
      dataBReady = 1'b0;
      send_word(32'h0BADCAFE, 1'b1);
      check("mr_b_pending", {31'd0, dataBValid}, 32'd1);
      for (int k = 0; k < 5; k++) push(4'hF, 1'b0);
      nibbleValid = 1'b0;
      check("mr_count5", {29'd0, count}, 32'd5);
      #3 reset_L = 1'b0;
      #1;
      check("mr_async_count",  {29'd0, count},       32'd0);
      check("mr_async_bvalid", {31'd0, dataBValid},  32'd0);
      check("mr_async_avalid", {31'd0, dataAValid},  32'd0);
      check("mr_async_ready",  {31'd0, nibbleReady}, 32'd0);
      tick();
      tick();
      reset_L = 1'b1;
      tick();
      dataAReady = 1'b1;
      send_word(32'h10000000, 1'b0);
      check("mr_clean_word",  dataA,               32'h10000000);
      check("mr_clean_valid", {31'd0, dataAValid}, 32'd1);
      check("mr_b_cleared",   dataB,               32'd0);
      check("mr_b_invalid",   {31'd0, dataBValid}, 32'd0);
      tick();

      // ---------------- Randomized run ----------------
      for (int w = 0; w < NW; w++) begin
         sels[w] = 1'($urandom_range(0, 1));
         for (int k = 0; k < 8; k++) nibs[w][k] = 4'($urandom_range(0, 15));
      end
      wi  = 0;
      ni  = 0;
      cyc = 0;
      while (wi < NW && cyc < 5000) begin
         nibbleValid = ($urandom_range(0, 9) < 7);
         nibbleIn    = nibs[wi][ni];
         sel         = (ni == 0) ? sels[wi] : 1'($urandom_range(0, 1));
         dataAReady  = 1'($urandom_range(0, 1));
         dataBReady  = 1'($urandom_range(0, 1));
         score_edge();
         if (nibbleValid && nibbleReady) begin
            ni++;
            if (ni == 8) begin
               if (sels[wi]) exp_b_q.push_back(model_word(wi));
               else          exp_a_q.push_back(model_word(wi));
               wi++;
               ni = 0;
            end
         end
         tick();
         cyc++;
      end
      check("rand_words_sent", 32'(wi), 32'(NW));
      nibbleValid = 1'b0;
      dataAReady  = 1'b1;
      dataBReady  = 1'b1;
      cyc = 0;
      while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && cyc < 100) begin
         score_edge();
         tick();
         cyc++;
      end
      check("drain_a_left", 32'(exp_a_q.size()), 32'd0);
      check("drain_b_left", 32'(exp_b_q.size()), 32'd0);
      tick();
      check("drain_a_idle", {31'd0, dataAValid}, 32'd0);
      check("drain_b_idle", {31'd0, dataBValid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
